// File: rtl/ir_pkg.sv
// ir_pkg: NEC IR state encoding and timing constants shared by the transmit and receive paths
package ir_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP,
    S_REP_SPACE
  } ir_state_t;
  localparam int T_LEAD_MARK  = 9000;
  localparam int T_LEAD_SPACE = 4500;
  localparam int T_BIT_MARK   = 560;
  localparam int T_ZERO_SPACE = 560;
  localparam int T_ONE_SPACE  = 1690;
  localparam int T_REP_SPACE  = 2250;
  localparam int T_FRAME      = 108000;
  localparam int NEC_BITS     = 32;
  localparam int DUR_W        = 17;
  localparam int BIT_W        = 5;
  function automatic logic is_mark(ir_state_t s);
    return s == S_LEAD_MARK || s == S_BIT_MARK || s == S_STOP_MARK;
  endfunction
  function automatic logic [NEC_BITS-1:0] nec_word(logic [15:0] custom, logic [7:0] data);
    return {~data, data, custom};
  endfunction
endpackage

// File: rtl/ir_tick_gen.sv
// ir_tick_gen: one-cycle tick every DIV clocks, synchronous clear restarts a full period
module ir_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/ir_tx.sv
// ir_tx: NEC frame transmitter with repeat chaining; IR_TX_CARRIER_EN modulates marks with a 1/3-duty carrier
module ir_tx
  import ir_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int CARRIER_HZ     = 38_000,
  parameter int LEAD_MARK_US   = T_LEAD_MARK,
  parameter int LEAD_SPACE_US  = T_LEAD_SPACE,
  parameter int BIT_MARK_US    = T_BIT_MARK,
  parameter int ZERO_SPACE_US  = T_ZERO_SPACE,
  parameter int ONE_SPACE_US   = T_ONE_SPACE,
  parameter int REP_SPACE_US   = T_REP_SPACE,
  parameter int FRAME_US       = T_FRAME
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_repeat,
  input  logic [15:0] i_custom,
  input  logic [7:0]  i_data,
  output logic        o_ir_tx,
  output logic        o_busy,
  output logic        o_done
);
  // duration limits are stored as N-1 so a state ends on its N-th tick
  localparam logic [DUR_W-1:0] D_LM = DUR_W'(LEAD_MARK_US - 1);
  localparam logic [DUR_W-1:0] D_LS = DUR_W'(LEAD_SPACE_US - 1);
  localparam logic [DUR_W-1:0] D_BM = DUR_W'(BIT_MARK_US - 1);
  localparam logic [DUR_W-1:0] D_ZS = DUR_W'(ZERO_SPACE_US - 1);
  localparam logic [DUR_W-1:0] D_OS = DUR_W'(ONE_SPACE_US - 1);
  localparam logic [DUR_W-1:0] D_RS = DUR_W'(REP_SPACE_US - 1);
  localparam logic [DUR_W-1:0] D_FR = DUR_W'(FRAME_US - 1);
  localparam logic [DUR_W-1:0] F_FR = DUR_W'(FRAME_US);
  ir_state_t state, state_n;
  logic tick, accept, dur_end, gap_end, lead_entry, rep_frame;
  logic [DUR_W-1:0] dur, frame_t, limit;
  logic [BIT_W-1:0] bit_idx;
  logic [NEC_BITS-1:0] word;
  assign accept = state == S_IDLE && i_start;
  assign o_busy = state != S_IDLE;
  ir_tick_gen #(.DIV(CLK_HZ / 1_000_000)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .tick(tick)
  );
  always_comb begin
    limit = '0;
    case (state)
      S_LEAD_MARK:             limit = D_LM;
      S_LEAD_SPACE:            limit = D_LS;
      S_BIT_MARK, S_STOP_MARK: limit = D_BM;
      S_BIT_SPACE:             limit = word[bit_idx] ? D_OS : D_ZS;
      S_REP_SPACE:             limit = D_RS;
      default:                 limit = '0;
    endcase
  end
  assign dur_end = tick && dur == limit;
  assign gap_end = tick && frame_t >= D_FR;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       state_n = i_start ? S_LEAD_MARK : S_IDLE;
      S_LEAD_MARK:  state_n = dur_end ? (rep_frame ? S_REP_SPACE : S_LEAD_SPACE) : state;
      S_LEAD_SPACE: state_n = dur_end ? S_BIT_MARK : state;
      S_BIT_MARK:   state_n = dur_end ? S_BIT_SPACE : state;
      S_BIT_SPACE:  state_n = dur_end ? (bit_idx == BIT_W'(NEC_BITS - 1) ? S_STOP_MARK : S_BIT_MARK) : state;
      S_REP_SPACE:  state_n = dur_end ? S_STOP_MARK : state;
      S_STOP_MARK:  state_n = dur_end ? S_GAP : state;
      S_GAP:        state_n = gap_end ? (i_repeat ? S_LEAD_MARK : S_IDLE) : state;
      default:      state_n = S_IDLE;
    endcase
  end
  assign lead_entry = state_n == S_LEAD_MARK && state != S_LEAD_MARK;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dur       <= '0;
      frame_t   <= '0;
      bit_idx   <= '0;
      word      <= '0;
      rep_frame <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      o_done    <= state == S_GAP && gap_end && !i_repeat;
      dur       <= (state_n != state || state == S_IDLE) ? '0 : dur + DUR_W'(tick);
      frame_t   <= lead_entry ? '0 : frame_t + DUR_W'(tick && frame_t != F_FR);
      bit_idx   <= lead_entry ? '0 : bit_idx + BIT_W'(state == S_BIT_SPACE && dur_end);
      if (accept) word <= nec_word(i_custom, i_data);
      if (lead_entry) rep_frame <= state == S_GAP;
    end
  end
`ifdef IR_TX_CARRIER_EN
  localparam int CP = CLK_HZ / CARRIER_HZ;
  localparam int PW = $clog2(CP);
  logic [PW-1:0] phase;
  always_ff @(posedge clk) begin
    if (rst || (is_mark(state_n) && state_n != state)) phase <= '0;
    else phase <= phase == PW'(CP - 1) ? '0 : phase + 1'b1;
  end
  assign o_ir_tx = is_mark(state) && phase < PW'(CP / 3);
`else
  assign o_ir_tx = is_mark(state);
`endif
endmodule
